sw_pattern_gen: RTL and testbench
=================================

Name: sw_pattern_gen

Overview:
- Synthesisable, parametrised successor to the fixed +1-every-10ns switch stimulus used for the lab src blocks.
- Generates a WIDTH-bit switch vector (sw_out) that steps at a programmable rate, under start/stop control, in one of several modes.
- Sits between board controls/test logic and any lab module taking a sw bus. The same block drives both the FPGA demo and the bench.

Parameters:
- WIDTH, 16, width of sw_out and seed
- DIV_W, 8, width of the period field (step divider counter)
- CNT_W, 16, width of count_lim and the internal step counter
- INIT, 16'h0000 (WIDTH bits), sw_out value after reset
- TAPS, 16'hB400, Galois LFSR feedback mask (used only with SW_PATGEN_LFSR_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin run; mode, period and count_lim are sampled this cycle
- stop  in  1  abort run
- load  in  1  load seed into sw_out (IDLE/DONE only)
- seed  in  WIDTH  value loaded by load
- mode  in  2  0=up, 1=down, 2=walking-one, 3=LFSR/hold
- period  in  DIV_W  a step occurs every period+1 cycles
- count_lim  in  CNT_W  number of steps per run; 0 = unbounded
- sw_out  out  WIDTH  generated switch vector (registered)
- step  out  1  1-cycle pulse, high in the same cycle that sw_out shows a new value
- busy  out  1  high in RUN
- done  out  1  high in DONE, held

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, sw_out=INIT, step=0, busy=0, done=0, div_cnt=0, step_cnt=0. Reset mid-run aborts immediately with no step.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are registered, with no combinational path from inputs.
- Input priority each cycle: stop > start > load.
- IDLE/DONE:
  - start -> RUN next cycle; latch mode/period/count_lim; clear div_cnt, step_cnt and done; sw_out unchanged.
  - load (without start) -> sw_out=seed next cycle; state unchanged.
  - stop -> IDLE, done cleared.
- RUN:
  - div_cnt counts 0..period_l, then wraps to 0.
  - On the cycle div_cnt==period_l: the next edge updates sw_out, pulses step and increments step_cnt.
  - First step appears period_l+1 cycles after the start edge. period=0 gives a step every cycle.
- RUN input handling: load and seed are ignored. start is ignored (no restart).
- stop in RUN -> IDLE next edge. sw_out keeps its current value. No step that cycle even if the divider tick coincides.
- Step functions (modulo 2^WIDTH):
  - up: sw_out+1; wraps all-ones -> 0.
  - down: sw_out-1; wraps 0 -> all-ones.
  - walking-one: rotate left by 1; MSB wraps to bit0. If sw_out==0, the next value is 1.
  - mode 3: see Optional Feature.
- Completion: when count_lim_l!=0 and the step making step_cnt==count_lim_l occurs, state -> DONE on that same edge. step=1 and done=1 appear together; sw_out holds its final value.
- count_lim_l==0: run until stop. step_cnt wraps silently.
- Latched mode/period are unaffected by input changes during RUN.

Optional Feature:
- Macro SW_PATGEN_LFSR_EN.
- Defined: mode 3 = Galois LFSR step, next = (sw_out>>1) ^ (sw_out[0] ? TAPS : 0). A zero state is replaced by 1 on the step.
- Undefined: mode 3 = hold. step still pulses and counts, but sw_out is unchanged. TAPS is unused.

Decomposition:
- Package sw_patgen_pkg holds:
  - mode enum MODE_UP=0, MODE_DOWN=1, MODE_WALK=2, MODE_LFSR=3
  - state enum ST_IDLE, ST_RUN, ST_DONE
  - default TAPS constant
- One sub-module: sw_step_div (DIV_W counter with clear/enable), outputs tick when count==period.
- The FSM and next-value mux stay in the top level.

Test Plan:
- Reset with INIT=0, then no stimulus for 20 cycles -> sw_out=0x0000, step/busy/done=0 throughout.
- load seed=0x1111; start mode=0, period=0, count_lim=5 -> sw_out 0x1112..0x1116 on 5 consecutive cycles, step high each; done=1 with the 0x1116 step; busy falls.
- seed=0x0000, mode=1, period=4, count_lim=2 -> first step 5 cycles after start gives 0xFFFF, then 0xFFFE 5 cycles later; done.
- seed=0x8000, mode=2, period=0, count_lim=0 -> 0x0001, 0x0002, 0x0004…; stop on the 3rd tick cycle -> IDLE, sw_out=0x0002, no step. Also seed=0 -> first step gives 0x0001.
- Assert rst_n=0 mid-RUN and start+stop together in IDLE -> IDLE and sw_out=INIT on the reset edge; start+stop stays IDLE with no load applied.
- With SW_PATGEN_LFSR_EN: seed=0x0001, mode=3 -> 0xB400, 0x5A00. Without the macro: sw_out stays 0x0001 while step still pulses.

Source files
------------

// File: rtl/sw_patgen_pkg.sv
// sw_patgen_pkg
// Shared types and constants for the switch pattern generator.
//   mode_e  : step function selected at start (up, down, walking-one, LFSR/hold)
//   state_e : run-control states of the generator
//   DEFAULT_TAPS : Galois LFSR feedback mask for a 16-bit maximal-length sequence
// Optional feature macro: SW_PATGEN_LFSR_EN (consumed by sw_pattern_gen).
package sw_patgen_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_WALK = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/sw_step_div.sv
// sw_step_div
// Step-rate divider: counts 0..period and wraps, flagging the cycle where the
// count equals period so the parent can commit a step on the following edge.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : force the count back to zero (held while not running)
//   en         : advance the count this cycle
//   period     : terminal count; a tick occurs every period+1 enabled cycles
//   tick       : high while enabled and count == period
module sw_step_div
  import sw_patgen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // The tick is decoded from the registered count, so the parent sees it in
  // the last cycle of each interval and the count restarts on the same edge.
  always_comb begin
    tick  = en && (cnt_q == period);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sw_pattern_gen.sv
// sw_pattern_gen
// Programmable switch-vector stimulus generator. After start it steps sw_out
// every period+1 cycles using the latched mode, for count_lim steps
// (0 = until stop), then parks in DONE with the final value held.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : begin a run; mode/period/count_lim are latched on this edge
//   stop       : abort (highest priority), returns to IDLE keeping sw_out
//   load, seed : load seed into sw_out while IDLE or DONE
//   mode       : 0 up, 1 down, 2 walking-one, 3 LFSR (or hold)
//   period     : step interval minus one
//   count_lim  : steps per run, 0 = unbounded
//   sw_out     : generated switch vector (registered)
//   step       : one-cycle pulse coincident with each new sw_out value
//   busy, done : registered state flags for RUN and DONE
// Optional feature macro: SW_PATGEN_LFSR_EN. When defined, mode 3 is a Galois
// LFSR step using TAPS; when undefined, mode 3 holds sw_out but still counts.
module sw_pattern_gen
  import sw_patgen_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               DIV_W = 8,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] count_lim,
  output logic [WIDTH-1:0] sw_out,
  output logic             step,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_l_q, mode_l_d;
  logic [DIV_W-1:0] period_l_q, period_l_d;
  logic [CNT_W-1:0] count_lim_l_q, count_lim_l_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] next_val;
  logic             tick;

  // Divider is held cleared outside RUN, so every run starts from count 0.
  sw_step_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ST_RUN),
    .en    (state_q == ST_RUN),
    .period(period_l_q),
    .tick  (tick)
  );

  // Next sw_out value for the latched mode. A zero vector cannot walk or
  // advance an LFSR, so both of those modes restart from 1.
  always_comb begin
    next_val = sw_q;
    case (mode_l_q)
      MODE_UP:   next_val = sw_q + 1'b1;
      MODE_DOWN: next_val = sw_q - 1'b1;
      MODE_WALK: begin
        if (sw_q == '0) begin
          next_val = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          next_val = {sw_q[WIDTH-2:0], sw_q[WIDTH-1]};
        end
      end
      MODE_LFSR: begin
`ifdef SW_PATGEN_LFSR_EN
        if (sw_q == '0) begin
          next_val = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          next_val = (sw_q >> 1) ^ (sw_q[0] ? TAPS : '0);
        end
`else
        next_val = sw_q;
`endif
      end
      default:   next_val = sw_q;
    endcase
  end

  // Run-control FSM. Priority is stop > start > load; busy/done are derived
  // from the next state so they are registered alongside it, and completion
  // raises done on the same edge as the final step.
  always_comb begin
    state_d       = state_q;
    mode_l_d      = mode_l_q;
    period_l_d    = period_l_q;
    count_lim_l_d = count_lim_l_q;
    step_cnt_d    = step_cnt_q;
    sw_d          = sw_q;
    step_d        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          sw_d       = next_val;
          step_d     = 1'b1;
          step_cnt_d = step_cnt_q + 1'b1;
          if ((count_lim_l_q != '0) && (step_cnt_d == count_lim_l_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d       = ST_RUN;
          mode_l_d      = mode_e'(mode);
          period_l_d    = period;
          count_lim_l_d = count_lim;
          step_cnt_d    = '0;
        end else if (load) begin
          sw_d = seed;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_l_q      <= MODE_UP;
      period_l_q    <= '0;
      count_lim_l_q <= '0;
      step_cnt_q    <= '0;
      sw_q          <= INIT;
      step_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_l_q      <= mode_l_d;
      period_l_q    <= period_l_d;
      count_lim_l_q <= count_lim_l_d;
      step_cnt_q    <= step_cnt_d;
      sw_q          <= sw_d;
      step_q        <= step_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign sw_out = sw_q;
  assign step   = step_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sw_pattern_gen.sv
// tb_sw_pattern_gen
// Directed bench for sw_pattern_gen with default parameters (INIT = 0).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. just after the edge that produced them.
// Honours SW_PATGEN_LFSR_EN for the expected mode-3 values.
module tb_sw_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        load;
  logic [15:0] seed;
  logic [1:0]  mode;
  logic [7:0]  period;
  logic [15:0] count_lim;
  logic [15:0] sw_out;
  logic        step;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  sw_pattern_gen #(
    .WIDTH(16),
    .DIV_W(8),
    .CNT_W(16),
    .INIT (16'h0000),
    .TAPS (16'hB400)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .seed     (seed),
    .mode     (mode),
    .period   (period),
    .count_lim(count_lim),
    .sw_out   (sw_out),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    seed = '0; mode = '0; period = '0; count_lim = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({sw_out, step, busy, done} !== {16'h0000, 3'b000}) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got sw=%h step=%b busy=%b done=%b, expected sw=0000 step=0 busy=0 done=0",
                 i, sw_out, step, busy, done);
      end
      cyc();
    end
  endtask

  task automatic test_up_count();
    logic [15:0] exp_sw;
    load = 1'b1; seed = 16'h1111;
    cyc();
    load = 1'b0;
    checks++;
    if (sw_out !== 16'h1111) begin
      errors++;
      $display("[TB] FAIL up_load: got %h expected 1111", sw_out);
    end
    start = 1'b1; mode = 2'd0; period = 8'd0; count_lim = 16'd5;
    cyc();
    start = 1'b0;
    checks++;
    if ({sw_out, step, busy, done} !== {16'h1111, 3'b010}) begin
      errors++;
      $display("[TB] FAIL up_start: got sw=%h step=%b busy=%b done=%b expected sw=1111 step=0 busy=1 done=0",
               sw_out, step, busy, done);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      exp_sw = 16'h1111 + 16'(i);
      checks++;
      if ({sw_out, step, busy, done} !== {exp_sw, 1'b1, (i != 5), (i == 5)}) begin
        errors++;
        $display("[TB] FAIL up_step %0d: got sw=%h step=%b busy=%b done=%b expected sw=%h step=1 busy=%b done=%b",
                 i, sw_out, step, busy, done, exp_sw, (i != 5), (i == 5));
      end
    end
    cyc();
    checks++;
    if ({sw_out, step, busy, done} !== {16'h1116, 3'b001}) begin
      errors++;
      $display("[TB] FAIL up_done_hold: got sw=%h step=%b busy=%b done=%b expected sw=1116 step=0 busy=0 done=1",
               sw_out, step, busy, done);
    end
  endtask

  task automatic test_down_period();
    logic [15:0] exp_sw;
    // Load works from DONE.
    load = 1'b1; seed = 16'h0000;
    cyc();
    load = 1'b0;
    checks++;
    if ({sw_out, done} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL down_load_in_done: got sw=%h done=%b expected sw=0000 done=1", sw_out, done);
    end
    start = 1'b1; mode = 2'd1; period = 8'd4; count_lim = 16'd2;
    cyc();
    // Changing inputs after start must not affect the latched run.
    start = 1'b0; mode = 2'd2; period = 8'd0; count_lim = 16'd0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL down_start: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      exp_sw = (k < 5) ? 16'h0000 : ((k < 10) ? 16'hFFFF : 16'hFFFE);
      checks++;
      if ({sw_out, step, done} !== {exp_sw, (k % 5 == 0), (k == 10)}) begin
        errors++;
        $display("[TB] FAIL down_cycle %0d: got sw=%h step=%b done=%b expected sw=%h step=%b done=%b",
                 k, sw_out, step, done, exp_sw, (k % 5 == 0), (k == 10));
      end
    end
    // Stop from DONE returns to IDLE and clears done.
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if ({sw_out, busy, done} !== {16'hFFFE, 2'b00}) begin
      errors++;
      $display("[TB] FAIL down_stop_in_done: got sw=%h busy=%b done=%b expected sw=fffe busy=0 done=0",
               sw_out, busy, done);
    end
  endtask

  task automatic test_walk_stop();
    load = 1'b1; seed = 16'h8000;
    cyc();
    // start together with load: start wins, seed 0xABCD is not loaded,
    // and load stays asserted through the run where it must be ignored.
    start = 1'b1; load = 1'b1; seed = 16'hABCD;
    mode = 2'd2; period = 8'd0; count_lim = 16'd0;
    cyc();
    start = 1'b0;
    checks++;
    if ({sw_out, busy} !== {16'h8000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL walk_start_over_load: got sw=%h busy=%b expected sw=8000 busy=1", sw_out, busy);
    end
    cyc();
    checks++;
    if ({sw_out, step} !== {16'h0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL walk_step1: got sw=%h step=%b expected sw=0001 step=1", sw_out, step);
    end
    cyc();
    checks++;
    if ({sw_out, step} !== {16'h0002, 1'b1}) begin
      errors++;
      $display("[TB] FAIL walk_step2: got sw=%h step=%b expected sw=0002 step=1", sw_out, step);
    end
    // Third tick cycle: stop suppresses the step.
    stop = 1'b1;
    cyc();
    stop = 1'b0; load = 1'b0;
    checks++;
    if ({sw_out, step, busy, done} !== {16'h0002, 3'b000}) begin
      errors++;
      $display("[TB] FAIL walk_stop: got sw=%h step=%b busy=%b done=%b expected sw=0002 step=0 busy=0 done=0",
               sw_out, step, busy, done);
    end
  endtask

  task automatic test_walk_zero_seed();
    load = 1'b1; seed = 16'h0000;
    cyc();
    load = 1'b0;
    start = 1'b1; mode = 2'd2; period = 8'd0; count_lim = 16'd1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if ({sw_out, step, busy, done} !== {16'h0001, 3'b101}) begin
      errors++;
      $display("[TB] FAIL walk_zero: got sw=%h step=%b busy=%b done=%b expected sw=0001 step=1 busy=0 done=1",
               sw_out, step, busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    load = 1'b1; seed = 16'h1234;
    cyc();
    load = 1'b0;
    start = 1'b1; mode = 2'd0; period = 8'd3; count_lim = 16'd0;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    // Divider now sits at its terminal count; reset must win.
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({sw_out, step, busy, done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: got sw=%h step=%b busy=%b done=%b expected sw=0000 step=0 busy=0 done=0",
               sw_out, step, busy, done);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({sw_out, step, busy} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("[TB] FAIL reset_release: got sw=%h step=%b busy=%b expected sw=0000 step=0 busy=0",
               sw_out, step, busy);
    end
  endtask

  task automatic test_start_stop_idle();
    load = 1'b1; seed = 16'h5555;
    cyc();
    start = 1'b1; stop = 1'b1; load = 1'b1; seed = 16'hAAAA;
    mode = 2'd0; period = 8'd0; count_lim = 16'd0;
    cyc();
    start = 1'b0; stop = 1'b0; load = 1'b0;
    checks++;
    if ({sw_out, step, busy, done} !== {16'h5555, 3'b000}) begin
      errors++;
      $display("[TB] FAIL start_stop_idle: got sw=%h step=%b busy=%b done=%b expected sw=5555 step=0 busy=0 done=0",
               sw_out, step, busy, done);
    end
    cyc();
    checks++;
    if ({sw_out, busy} !== {16'h5555, 1'b0}) begin
      errors++;
      $display("[TB] FAIL start_stop_settle: got sw=%h busy=%b expected sw=5555 busy=0", sw_out, busy);
    end
  endtask

  task automatic test_mode3();
    logic [15:0] exp1;
    logic [15:0] exp2;
`ifdef SW_PATGEN_LFSR_EN
    exp1 = 16'hB400;
    exp2 = 16'h5A00;
`else
    exp1 = 16'h0001;
    exp2 = 16'h0001;
`endif
    load = 1'b1; seed = 16'h0001;
    cyc();
    load = 1'b0;
    start = 1'b1; mode = 2'd3; period = 8'd1; count_lim = 16'd2;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if ({sw_out, step} !== {16'h0001, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mode3_wait: got sw=%h step=%b expected sw=0001 step=0", sw_out, step);
    end
    cyc();
    checks++;
    if ({sw_out, step, done} !== {exp1, 2'b10}) begin
      errors++;
      $display("[TB] FAIL mode3_step1: got sw=%h step=%b done=%b expected sw=%h step=1 done=0",
               sw_out, step, done, exp1);
    end
    cyc();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mode3_gap: got step=%b expected step=0", step);
    end
    cyc();
    checks++;
    if ({sw_out, step, busy, done} !== {exp2, 3'b101}) begin
      errors++;
      $display("[TB] FAIL mode3_step2: got sw=%h step=%b busy=%b done=%b expected sw=%h step=1 busy=0 done=1",
               sw_out, step, busy, done, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_period();
    test_walk_stop();
    test_walk_zero_seed();
    test_reset_mid_run();
    test_start_stop_idle();
    test_mode3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
